digit_scan_ctrl: RTL and testbench

//  Time-multiplexed scan sequencer for the 6-digit seven-segment clock display.

---
 rtl/digit_scan_ctrl_pkg.sv | 13 +
 rtl/digit_scan_ctrl_lzb_mask.sv | 27 ++
 rtl/digit_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the display scan sequencer and the position decoder.
package digit_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Position code meaning "no digit lit".
  localparam logic [3:0] POS_NONE = 4'hF;

endpackage

// File: rtl/digit_scan_ctrl_lzb_mask.sv
// Leading-zero suppression mask for the digit scanner.
// A digit is suppressed when it and every digit above it are zero and none of
// those digits has its decimal point lit; digit 0 is never suppressed.
module scan_lzb_mask
  import digit_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic [4*NUM_DIGITS-1:0] frame,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   suppress
);

  logic keep;

  // Walk from the leftmost digit down; the first non-zero digit or lit dp stops suppression.
  always_comb begin
    suppress = '0;
    keep     = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      keep        = keep | (frame[4*k +: 4] != 4'd0) | dp[k];
      suppress[k] = lzb & ~keep;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan sequencer for the seven-segment clock display.
//
//   state | meaning
//   IDLE  | display off, waiting for en
//   BLANK | all digits off (ghost-blanking gap before each digit)
//   SHOW  | digit idx lit for its dwell time
//
// The frame buffer only changes in IDLE or on the frame_tick cycle, so a
// frame never mixes old and new digits.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    lzb,
  input  logic                    upd_req,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    upd_ack,
  output logic [3:0]              scan_pos,
  output logic [3:0]              scan_val,
  output logic                    scan_dp,
  output logic                    frame_tick
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t           state_q, nxt_state;
  logic [IW-1:0]         idx_q, nxt_idx;
  logic [TW-1:0]         timer_q, nxt_timer;
  logic [4*NUM_DIGITS-1:0] frame_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [NUM_DIGITS-1:0] suppress;
  logic [3:0]            nxt_pos, nxt_val;
  logic                  nxt_dp, nxt_tick;
  logic                  capture;

  scan_lzb_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lzb_mask (
    .frame    (frame_q),
    .dp       (dp_q),
    .lzb      (lzb),
    .suppress (suppress)
  );

  // Capture only in IDLE or on the frame boundary, never while the previous ack is out.
  assign capture = upd_req & ~upd_ack & ((state_q == ST_IDLE) | frame_tick);

  // Next state, index and timer.
  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q;
    nxt_timer = timer_q;
    if (!en) begin
      nxt_state = ST_IDLE;
      nxt_idx   = '0;
      nxt_timer = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          nxt_state = ST_BLANK;
          nxt_idx   = '0;
          nxt_timer = '0;
        end
        ST_BLANK: begin
          if (timer_q == TW'(BLANK_CYCLES - 1)) begin
            nxt_state = ST_SHOW;
            nxt_timer = '0;
          end else begin
            nxt_timer = timer_q + TW'(1);
          end
        end
        ST_SHOW: begin
          if (timer_q == TW'(DWELL_CYCLES - 1)) begin
            nxt_state = ST_BLANK;
            nxt_timer = '0;
            nxt_idx   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
          end else begin
            nxt_timer = timer_q + TW'(1);
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
          nxt_timer = '0;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state so outputs stay registered.
  always_comb begin
    nxt_pos  = POS_NONE;
    nxt_val  = '0;
    nxt_dp   = 1'b0;
    nxt_tick = 1'b0;
    if (nxt_state == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (nxt_idx == IW'(k)) begin
          nxt_val = frame_q[4*k +: 4];
          nxt_dp  = dp_q[k];
          if (!suppress[k]) nxt_pos = 4'(k);
        end
      end
      nxt_tick = (nxt_idx == IW'(NUM_DIGITS - 1)) && (nxt_timer == TW'(DWELL_CYCLES - 1));
    end
  end

  // FSM state, index and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= nxt_state;
      idx_q   <= nxt_idx;
      timer_q <= nxt_timer;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_pos   <= POS_NONE;
      scan_val   <= '0;
      scan_dp    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      scan_pos   <= nxt_pos;
      scan_val   <= nxt_val;
      scan_dp    <= nxt_dp;
      frame_tick <= nxt_tick;
    end
  end

  // Frame buffer and update acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      dp_q    <= '0;
      upd_ack <= 1'b0;
    end else begin
      upd_ack <= capture;
      if (capture) begin
        frame_q <= digits_in;
        dp_q    <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl with a short-timing configuration.
module tb_digit_scan_ctrl;

  localparam int N     = 6;
  localparam int D     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + D;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          lzb = 1'b0;
  logic          upd_req = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic          upd_ack;
  logic [3:0]    scan_pos;
  logic [3:0]    scan_val;
  logic          scan_dp;
  logic          frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  digit_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lzb        (lzb),
    .upd_req    (upd_req),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .upd_ack    (upd_ack),
    .scan_pos   (scan_pos),
    .scan_val   (scan_val),
    .scan_dp    (scan_dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scanning is described as "cycles since scanning began"; position within
  // the frame gives the digit and whether it is in its blank gap.
  bit         m_run = 1'b0;
  int         m_t = 0;
  int         m_buf [N] = '{default: 0};
  bit         m_dp [N] = '{default: 1'b0};
  logic [3:0] e_pos = 4'hF;
  logic [3:0] e_val = 4'h0;
  logic       e_dp = 1'b0;
  logic       e_ack = 1'b0;
  logic       e_tick = 1'b0;
  bit         chk_en = 1'b0;

  function automatic bit suppressed(input int d);
    if (!lzb || d == 0) return 1'b0;
    for (int j = d; j < N; j++)
      if (m_buf[j] != 0 || m_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  bit m_cap;
  int m_p, m_d, m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_t   = 0;
      for (int k = 0; k < N; k++) begin
        m_buf[k] = 0;
        m_dp[k]  = 1'b0;
      end
      e_pos = 4'hF; e_val = 4'h0; e_dp = 1'b0; e_ack = 1'b0; e_tick = 1'b0;
    end else begin
      m_cap = upd_req && !e_ack && (!m_run || e_tick);
      if (!en) m_run = 1'b0;
      else if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else m_t++;
      e_pos = 4'hF; e_val = 4'h0; e_dp = 1'b0; e_tick = 1'b0;
      if (m_run) begin
        m_p = m_t % FRAME;
        m_d = m_p / SLOT;
        m_w = m_p % SLOT;
        e_tick = (m_d == N - 1) && (m_w == SLOT - 1);
        if (m_w >= B && !suppressed(m_d)) begin
          e_pos = 4'(m_d);
          e_val = 4'(m_buf[m_d]);
          e_dp  = m_dp[m_d];
        end
      end
      if (m_cap) begin
        for (int k = 0; k < N; k++) begin
          m_buf[k] = int'(digits_in[4*k +: 4]);
          m_dp[k]  = dp_in[k];
        end
      end
      e_ack = m_cap;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pos", 32'(scan_pos), 32'(e_pos));
      if (e_pos != 4'hF) check("val", 32'(scan_val), 32'(e_val));
      check("dp", 32'(scan_dp), 32'(e_dp));
      check("ack", 32'(upd_ack), 32'(e_ack));
      check("tick", 32'(frame_tick), 32'(e_tick));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_pos(input logic [3:0] p, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (scan_pos == p) break;
    end
    check("wait_pos", 32'(scan_pos), 32'(p));
  endtask

  task automatic wait_tick(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    check("wait_tick", 32'(frame_tick), 32'h1);
  endtask

  // Drive a request (called just after a negedge) and hold it until ack.
  task automatic load(input logic [4*N-1:0] v, input logic [N-1:0] dp, input int bound,
                      output bit pt);
    bit prev;
    prev = 1'b0;
    pt   = 1'b0;
    digits_in = v;
    dp_in     = dp;
    upd_req   = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (upd_ack) begin
        pt = prev;
        break;
      end
      prev = frame_tick;
    end
    check("wait_ack", 32'(upd_ack), 32'h1);
    #1 upd_req = 1'b0;
  endtask

  task automatic count_lit(output int n);
    n = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (scan_pos != 4'hF) n++;
    end
  endtask

  logic [3:0] seq1 [9] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h1};
  logic [3:0] seq4 [3] = '{4'hF, 4'hF, 4'h0};
  bit pt;
  int n;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_pos", 32'(scan_pos), 32'hF);
    check("rst_val", 32'(scan_val), 32'h0);
    check("rst_dp", 32'(scan_dp), 32'h0);
    check("rst_ack", 32'(upd_ack), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    #1 rst_n = 1'b1;

    // 1: load while idle, then scan
    @(negedge clk);
    #1 load(24'h654321, 6'h00, 10, pt);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t1_seq", 32'(scan_pos), 32'(seq1[i]));
      if (i == 2) check("t1_val0", 32'(scan_val), 32'h1);
    end
    wait_pos(4'd5, 40);
    check("t1_val5", 32'(scan_val), 32'h6);
    wait_tick(100);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (frame_tick) break;
    end
    check("t1_period", 32'(n), 32'd36);

    // 2: mid-frame request waits for the frame boundary
    wait_pos(4'd2, 40);
    #1 load(24'h999999, 6'h00, 60, pt);
    check("t2_ack_after_tick", 32'(pt), 32'h1);
    wait_pos(4'd0, 20);
    check("t2_new", 32'(scan_val), 32'h9);

    // 3: leading-zero blanking, then dp override
    @(negedge clk);
    #1 lzb = 1'b1;
    load(24'h000305, 6'h00, 80, pt);
    wait_tick(80);
    count_lit(n);
    check("t3_lit_cycles", 32'(n), 32'd12);
    wait_pos(4'd2, 40);
    check("t3_val2", 32'(scan_val), 32'h3);
    #1 load(24'h000305, 6'b010000, 80, pt);
    wait_tick(80);
    count_lit(n);
    check("t3_dp_lit_cycles", 32'(n), 32'd20);

    // 4: en dropped during SHOW of digit 3
    @(negedge clk);
    #1 lzb = 1'b0;
    load(24'h654321, 6'h00, 80, pt);
    wait_pos(4'd3, 40);
    @(negedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("t4_off", 32'(scan_pos), 32'hF);
    repeat (2) @(negedge clk);
    #1 en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_restart", 32'(scan_pos), 32'(seq4[i]));
    end

    // 5: reset pulse while a request is pending
    wait_pos(4'd2, 40);
    #1 digits_in = 24'h777777;
    upd_req = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_pos", 32'(scan_pos), 32'hF);
    check("t5_val", 32'(scan_val), 32'h0);
    check("t5_ack", 32'(upd_ack), 32'h0);
    check("t5_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    upd_req = 1'b0;
    wait_pos(4'd0, 20);
    check("t5_buf0", 32'(scan_val), 32'h0);
    check("t5_noack", 32'(upd_ack), 32'h0);

    // 6: request raised on the frame_tick cycle itself
    wait_tick(80);
    #1 digits_in = 24'h112233;
    dp_in   = 6'h00;
    upd_req = 1'b1;
    @(negedge clk);
    check("t6_ack", 32'(upd_ack), 32'h1);
    #1 upd_req = 1'b0;
    wait_pos(4'd0, 10);
    check("t6_new", 32'(scan_val), 32'h3);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
